// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_regfile
//  Description : AXI4-Lite slave with an internal register file. NUM_REGS
//                words, per-register RW/RO selection, byte-strobe writes,
//                SLVERR on illegal access, full AW/W/B/AR/R backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int                    c_BW     = DATA_WIDTH / 8;
    localparam int                    c_LSB    = $clog2(c_BW);
    localparam int                    c_IDXW   = $clog2(NUM_REGS);
    // Addresses at or above this byte offset are illegal; upper bits never alias.
    localparam logic [ADDR_WIDTH-1:0] c_LIMIT  = ADDR_WIDTH'(NUM_REGS * c_BW);
    localparam logic [1:0]            c_OKAY   = 2'b00;
    localparam logic [1:0]            c_SLVERR = 2'b10;

    // Register file and unpacked view of the status words
    logic [DATA_WIDTH-1:0]   r_regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0]   w_status [NUM_REGS];

    // Write channel state
    logic                    r_aw_held, r_w_held, r_awready, r_wready;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_BW-1:0]         r_wstrb;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic [NUM_REGS-1:0]     r_wr_pulse;

    // Read channel state
    logic                    r_ar_held, r_arready, r_rvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    // Combinational decode / next-state
    logic                    w_aw_hs, w_w_hs, w_ar_hs;
    logic                    w_commit, w_wr_legal, w_wr_ok;
    logic                    w_aw_held_nx, w_w_held_nx, w_bvalid_nx;
    logic                    w_ar_held_nx, w_rvalid_nx;
    logic [c_IDXW-1:0]       w_wr_idx, w_rd_idx;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic [1:0]              w_rd_resp;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
            assign w_status[i] = status_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign wr_pulse      = r_wr_pulse;

    assign w_aw_hs    = S_AXI_AWVALID & r_awready;
    assign w_w_hs     = S_AXI_WVALID & r_wready;
    assign w_ar_hs    = S_AXI_ARVALID & r_arready;
    assign w_wr_idx   = r_awaddr[c_LSB +: c_IDXW];
    assign w_rd_idx   = r_araddr[c_LSB +: c_IDXW];
    // A commit fires on the first edge at which both AW and W are held.
    assign w_commit   = r_aw_held & r_w_held;
    assign w_wr_legal = (r_awaddr < c_LIMIT) && !RO_MASK[w_wr_idx];
    assign w_wr_ok    = w_commit & w_wr_legal;

    // Holding/valid next-state; READYs are registered from these
    always_comb begin
        w_aw_held_nx = w_commit ? 1'b0 : (r_aw_held | w_aw_hs);
        w_w_held_nx  = w_commit ? 1'b0 : (r_w_held | w_w_hs);
        w_bvalid_nx  = w_commit ? 1'b1 : (r_bvalid & ~S_AXI_BREADY);
        w_ar_held_nx = r_ar_held ? 1'b0 : w_ar_hs;
        w_rvalid_nx  = r_ar_held ? 1'b1 : (r_rvalid & ~S_AXI_RREADY);
    end

    // Byte-lane merge of the held write data into the addressed register
    always_comb begin
        w_merged = r_regs[w_wr_idx];
        for (int k = 0; k < c_BW; k++) begin
            if (r_wstrb[k]) begin
                w_merged[k*8 +: 8] = r_wdata[k*8 +: 8];
            end
        end
    end

    // Read data select; forwards a commit landing on the read sample edge
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_SLVERR;
        if (r_araddr < c_LIMIT) begin
            w_rd_resp = c_OKAY;
            if (RO_MASK[w_rd_idx]) begin
                w_rd_data = w_status[w_rd_idx];
            end else if (w_wr_ok && (w_wr_idx == w_rd_idx)) begin
                w_rd_data = w_merged;
            end else begin
                w_rd_data = r_regs[w_rd_idx];
            end
        end
    end

    // Write channel: AW/W holding registers, B response, READY generation
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
        end else begin
            r_aw_held <= w_aw_held_nx;
            r_w_held  <= w_w_held_nx;
            r_awready <= ~w_aw_held_nx & ~w_bvalid_nx;
            r_wready  <= ~w_w_held_nx & ~w_bvalid_nx;
            r_bvalid  <= w_bvalid_nx;
            if (w_aw_hs) begin
                r_awaddr <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_wr_legal ? c_OKAY : c_SLVERR;
            end
        end
    end

    // Register file update and one-cycle write strobes
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;
            if (w_wr_ok) begin
                r_regs[w_wr_idx]     <= w_merged;
                r_wr_pulse[w_wr_idx] <= 1'b1;
            end
        end
    end

    // Read channel: AR holding register and R response
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_ar_held <= 1'b0;
            r_arready <= 1'b0;
            r_araddr  <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_OKAY;
        end else begin
            r_ar_held <= w_ar_held_nx;
            r_arready <= ~w_ar_held_nx & ~w_rvalid_nx;
            r_rvalid  <= w_rvalid_nx;
            if (w_ar_hs) begin
                r_araddr <= S_AXI_ARADDR;
            end
            if (r_ar_held) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_regfile
//  Description : Self-checking bench for axi_lite_regfile: table-driven
//                single-beat transactions plus hand-written timing sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;

    localparam int NR = 16;

    logic          S_AXI_ACLK = 1'b0;
    logic          S_AXI_ARESET;
    logic [31:0]   S_AXI_AWADDR;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [31:0]   S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;
    logic [NR*32-1:0] reg_out;
    logic [NR*32-1:0] status_in;
    logic [NR-1:0] wr_pulse;

    int n_err = 0;
    int n_chk = 0;

    axi_lite_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NR),
        .RO_MASK    (16'h0008)
    ) u_dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .status_in     (status_in),
        .wr_pulse      (wr_pulse)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [15:0] pulse;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [15:0] pulse);
        bit aw_done, w_done, aw_fire, w_fire;
        int t;
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        t = 0;
        while (!(aw_done && w_done) && t < 20) begin
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_fire) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (w_fire)  begin w_done  = 1'b1; S_AXI_WVALID  = 1'b0; end
            t++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        t = 0;
        while (!S_AXI_BVALID && t < 20) begin
            tick();
            t++;
        end
        chk("wr_bvalid_seen", S_AXI_BVALID, 1);
        resp  = S_AXI_BRESP;
        pulse = wr_pulse;
        tick();
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit done;
        int t;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        done = 1'b0;
        t = 0;
        while (!done && t < 20) begin
            done = S_AXI_ARREADY;
            tick();
            t++;
        end
        S_AXI_ARVALID = 1'b0;
        t = 0;
        while (!S_AXI_RVALID && t < 20) begin
            tick();
            t++;
        end
        chk("rd_rvalid_seen", S_AXI_RVALID, 1);
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [15:0] pulse;

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 2'b00, 32'h0,         16'h0001};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 16'h0};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'h3, 2'b00, 32'h0,         16'h0001};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h1234_CCDD, 16'h0};
        vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 16'h0};
        vecs[5]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0,         16'h0000};
        vecs[6]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_A5A5, 16'h0};
        vecs[7]  = '{1'b1, 32'h0000_0040, 32'h1212_1212, 4'hF, 2'b10, 32'h0,         16'h0000};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b10, 32'h0,         16'h0};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h0,         16'h8000};
        vecs[10] = '{1'b0, 32'h0000_003E, 32'h0,         4'h0, 2'b00, 32'h0BAD_F00D, 16'h0};
        vecs[11] = '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 2'b10, 32'h0,         16'h0};
        vecs[12] = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0,         16'h0000};
        vecs[13] = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0,         16'h0020};
        vecs[14] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 2'b00, 32'h0,         16'h0};
        vecs[15] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0,         16'h0004};

        status_in = '0;
        status_in[0*32 +: 32] = 32'hCAFE_0000;   // must never show through on RW reg 0
        status_in[3*32 +: 32] = 32'h0000_A5A5;

        S_AXI_ARESET  = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_handshake", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
        chk("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'b0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_regs_any", |reg_out, 0);
        chk("rst_pulse", wr_pulse, 0);
        S_AXI_ARESET = 1'b0;
        tick();
        chk("rst_exit_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // ---- AW and W together: latency and pulse ----
        S_AXI_BREADY  = 1'b0;
        S_AXI_AWADDR  = 32'h4;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'hDEAD_BEEF;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("t1_bvalid_early", S_AXI_BVALID, 0);
        chk("t1_reg_early", reg_out[1*32 +: 32], 0);
        chk("t1_ready_drop", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
        tick();
        chk("t1_reg", reg_out[1*32 +: 32], 32'hDEAD_BEEF);
        chk("t1_pulse", wr_pulse, 16'h0002);
        chk("t1_bvalid", S_AXI_BVALID, 1);
        chk("t1_bresp", S_AXI_BRESP, 2'b00);
        tick();
        chk("t1_pulse_clear", wr_pulse, 0);
        chk("t1_bvalid_hold", S_AXI_BVALID, 1);
        S_AXI_BREADY = 1'b1;
        tick();
        chk("t1_bvalid_done", S_AXI_BVALID, 0);

        // ---- table-driven transactions ----
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
                chk($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
                chk($sformatf("v%0d_pulse", i), pulse, vecs[i].pulse);
            end else begin
                axi_read(vecs[i].addr, rd, resp);
                chk($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            end
        end
        chk("ro_reg_untouched", reg_out[3*32 +: 32], 0);

        // ---- W three cycles ahead of AW, strobed merge ----
        S_AXI_WDATA  = 32'h1122_3344;
        S_AXI_WSTRB  = 4'h5;
        S_AXI_WVALID = 1'b1;
        chk("t2_wready", S_AXI_WREADY, 1);
        tick();
        S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t2_wait%0d", c), {S_AXI_BVALID, S_AXI_WREADY, reg_out[2*32 +: 32]},
                {1'b0, 1'b0, 32'hFFFF_FFFF});
            tick();
        end
        S_AXI_AWADDR  = 32'h8;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("t2_no_early_commit", {S_AXI_BVALID, reg_out[2*32 +: 32]}, {1'b0, 32'hFFFF_FFFF});
        tick();
        chk("t2_reg", reg_out[2*32 +: 32], 32'hFF22_FF44);
        chk("t2_b", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
        chk("t2_pulse", wr_pulse, 16'h0004);
        tick();
        chk("t2_b_done", S_AXI_BVALID, 0);
        chk("regs_r0", reg_out[0*32 +: 32], 32'h1234_CCDD);
        chk("regs_r5", reg_out[5*32 +: 32], 0);
        chk("regs_r15", reg_out[15*32 +: 32], 32'h0BAD_F00D);

        // ---- backpressure on B and R, same-register read/write ----
        S_AXI_BREADY  = 1'b0;
        S_AXI_RREADY  = 1'b0;
        S_AXI_AWADDR  = 32'h10;
        S_AXI_WDATA   = 32'h0000_0055;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 32'h10;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWADDR = 32'h18;     // these must not be accepted while responses are pending
        S_AXI_WDATA  = 32'h0000_0077;
        S_AXI_ARADDR = 32'h0;
        tick();
        chk("t5_resp_up", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        chk("t5_rdata_fwd", S_AXI_RDATA, 32'h0000_0055);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("t5_hold%0d", c),
                {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                 S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA},
                {5'b11000, 4'b0000, 32'h0000_0055});
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_RREADY  = 1'b1;
        tick();
        chk("t5_released", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk("t5_reg4", reg_out[4*32 +: 32], 32'h0000_0055);
        chk("t5_reg6_untouched", reg_out[6*32 +: 32], 0);

        // ---- reset mid-transaction ----
        S_AXI_RREADY  = 1'b0;
        S_AXI_AWADDR  = 32'h0;
        S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR  = 32'h4;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARVALID = 1'b0;
        tick();
        chk("t6_rvalid_pending", S_AXI_RVALID, 1);
        S_AXI_ARESET = 1'b1;
        tick();
        chk("t6_handshake", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
        chk("t6_rdata", S_AXI_RDATA, 0);
        chk("t6_regs_any", |reg_out, 0);
        S_AXI_ARESET = 1'b0;
        S_AXI_RREADY = 1'b1;
        tick();
        chk("t6_ready_back", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        S_AXI_WDATA  = 32'h0000_0099;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        tick();
        tick();
        chk("t6_aw_discarded", {S_AXI_BVALID, reg_out[0*32 +: 32]}, {1'b0, 32'h0});
        S_AXI_AWADDR  = 32'h0;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        tick();
        chk("t6_commit_after", {S_AXI_BVALID, reg_out[0*32 +: 32]}, {1'b1, 32'h0000_0099});
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
